// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: operand-fetch front end for a banked vector register file.
//   One-entry request stage (S1) issues a two-port read per request, arbitrating
//   the shared warp selector against writebacks. Different-warp writebacks win
//   until a pending read has waited STARVE_LIMIT cycles. Same-warp writebacks
//   are bypassed into the operands in the issuing cycle.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   req_*                    operand-fetch request (warp, rs0/rs1, use_rs1, mask, tag)
//   wb_*                     writeback request (warp, addr, lane mask, data)
//   rf_read_en_*/rf_raddr_*  register-file read ports, rf_rdata_* returns same cycle
//   rf_write_en/waddr/wdata  register-file write port, commits at next edge
//   rf_warp_selector         warp select shared by all register-file ports
//   op_*                     registered operand output with valid/ready

module regfile_access_lane #(
   parameter int DW = 64
) (
   input  logic          i_lane_en,
   input  logic          i_use_rs1,
   input  logic          i_byp_0,
   input  logic          i_byp_1,
   input  logic [DW-1:0] i_wb_data,
   input  logic [DW-1:0] i_rdata_0,
   input  logic [DW-1:0] i_rdata_1,
   output logic [DW-1:0] o_data_0,
   output logic [DW-1:0] o_data_1
);
   always_comb begin
      o_data_0 = '0;
      o_data_1 = '0;
      if (i_lane_en) begin
         o_data_0 = i_byp_0 ? i_wb_data : i_rdata_0;
         if (i_use_rs1) o_data_1 = i_byp_1 ? i_wb_data : i_rdata_1;
      end
   end
endmodule

module regfile_access_ctrl #(
   parameter int LANES        = 16,
   parameter int DW           = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [2:0]          req_warp,
   input  logic [4:0]          req_rs0,
   input  logic [4:0]          req_rs1,
   input  logic                req_use_rs1,
   input  logic [LANES-1:0]    req_mask,
   input  logic [3:0]          req_tag,
   input  logic                wb_valid,
   output logic                wb_ready,
   input  logic [2:0]          wb_warp,
   input  logic [4:0]          wb_addr,
   input  logic [LANES-1:0]    wb_mask,
   input  logic [LANES*DW-1:0] wb_data,
   output logic [LANES-1:0]    rf_read_en_0,
   output logic [LANES-1:0]    rf_read_en_1,
   output logic [LANES-1:0]    rf_write_en,
   output logic [4:0]          rf_raddr_0,
   output logic [4:0]          rf_raddr_1,
   output logic [4:0]          rf_waddr,
   output logic [LANES*DW-1:0] rf_wdata,
   output logic [2:0]          rf_warp_selector,
   input  logic [LANES*DW-1:0] rf_rdata_0,
   input  logic [LANES*DW-1:0] rf_rdata_1,
   output logic                op_valid,
   input  logic                op_ready,
   output logic [2:0]          op_warp,
   output logic [3:0]          op_tag,
   output logic [LANES-1:0]    op_mask,
   output logic [LANES*DW-1:0] op_data_0,
   output logic [LANES*DW-1:0] op_data_1
);
   localparam logic [2:0] SL3 = 3'(STARVE_LIMIT);

   typedef struct packed {
      logic [2:0]       warp;
      logic [4:0]       rs0;
      logic [4:0]       rs1;
      logic             use_rs1;
      logic [LANES-1:0] mask;
      logic [3:0]       tag;
   } s1_t;

   s1_t                 r_s1;
   logic                r_s1_valid;
   logic [2:0]          r_starve_cnt;
   logic                r_op_valid;
   logic [2:0]          r_op_warp;
   logic [3:0]          r_op_tag;
   logic [LANES-1:0]    r_op_mask;
   logic [LANES*DW-1:0] r_op_data_0;
   logic [LANES*DW-1:0] r_op_data_1;

   logic                w_out_free;
   logic                w_wb_other;
   logic                w_rd_blocked;
   logic                w_s1_fire;
   logic                w_wb_fire;
   logic                w_byp_0;
   logic                w_byp_1;
   logic [LANES*DW-1:0] w_d0;
   logic [LANES*DW-1:0] w_d1;

   assign w_out_free   = !r_op_valid || op_ready;
   assign w_wb_other   = wb_warp != r_s1.warp;
   // Reads yield to a foreign-warp writeback until the counter saturates;
   // then the read takes the selector and the writeback is held off instead.
   assign w_rd_blocked = wb_valid && w_wb_other && (r_starve_cnt < SL3);
   assign w_s1_fire    = r_s1_valid && w_out_free && !w_rd_blocked;
   assign wb_ready     = !(r_s1_valid && w_out_free && w_wb_other && (r_starve_cnt == SL3));
   assign w_wb_fire    = wb_valid && wb_ready;
   assign req_ready    = !r_s1_valid || w_s1_fire;

   assign rf_read_en_0 = w_s1_fire ? r_s1.mask : '0;
   assign rf_read_en_1 = (w_s1_fire && r_s1.use_rs1) ? r_s1.mask : '0;
   assign rf_raddr_0   = r_s1.rs0;
   assign rf_raddr_1   = r_s1.rs1;
   assign rf_write_en  = w_wb_fire ? wb_mask : '0;
   assign rf_waddr     = wb_addr;
   assign rf_wdata     = wb_data;
   assign rf_warp_selector = w_wb_fire ? wb_warp : (r_s1_valid ? r_s1.warp : 3'd0);

   // A write accepted alongside an issue is always same-warp (foreign warps
   // either block the read or are stalled), so only the address needs matching.
   assign w_byp_0 = w_wb_fire && !w_wb_other && (wb_addr == r_s1.rs0);
   assign w_byp_1 = w_wb_fire && !w_wb_other && (wb_addr == r_s1.rs1);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      regfile_access_lane #(.DW(DW)) u_lane (
         .i_lane_en (r_s1.mask[i]),
         .i_use_rs1 (r_s1.use_rs1),
         .i_byp_0   (w_byp_0 && wb_mask[i]),
         .i_byp_1   (w_byp_1 && wb_mask[i]),
         .i_wb_data (wb_data[i*DW +: DW]),
         .i_rdata_0 (rf_rdata_0[i*DW +: DW]),
         .i_rdata_1 (rf_rdata_1[i*DW +: DW]),
         .o_data_0  (w_d0[i*DW +: DW]),
         .o_data_1  (w_d1[i*DW +: DW])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid   <= 1'b0;
         r_s1         <= '0;
         r_starve_cnt <= 3'd0;
      end else begin
         if (req_valid && req_ready) begin
            r_s1_valid   <= 1'b1;
            r_s1.warp    <= req_warp;
            r_s1.rs0     <= req_rs0;
            r_s1.rs1     <= req_rs1;
            r_s1.use_rs1 <= req_use_rs1;
            r_s1.mask    <= req_mask;
            r_s1.tag     <= req_tag;
         end else if (w_s1_fire) begin
            r_s1_valid <= 1'b0;
         end
         // Only count cycles where the writeback is the sole reason for waiting.
         if (w_s1_fire)
            r_starve_cnt <= 3'd0;
         else if (r_s1_valid && w_rd_blocked && w_out_free)
            r_starve_cnt <= r_starve_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_valid  <= 1'b0;
         r_op_warp   <= '0;
         r_op_tag    <= '0;
         r_op_mask   <= '0;
         r_op_data_0 <= '0;
         r_op_data_1 <= '0;
      end else if (w_s1_fire) begin
         r_op_valid  <= 1'b1;
         r_op_warp   <= r_s1.warp;
         r_op_tag    <= r_s1.tag;
         r_op_mask   <= r_s1.mask;
         r_op_data_0 <= w_d0;
         r_op_data_1 <= w_d1;
      end else if (op_ready) begin
         r_op_valid <= 1'b0;
      end
   end

   assign op_valid  = r_op_valid;
   assign op_warp   = r_op_warp;
   assign op_tag    = r_op_tag;
   assign op_mask   = r_op_mask;
   assign op_data_0 = r_op_data_0;
   assign op_data_1 = r_op_data_1;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file on the rf_* ports,
// golden register image, and a scoreboard of expected operand packets.
module tb_regfile_access_ctrl;
   localparam int LANES = 16;
   localparam int DW    = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                req_valid, req_ready, req_use_rs1;
   logic [2:0]          req_warp;
   logic [4:0]          req_rs0, req_rs1;
   logic [LANES-1:0]    req_mask;
   logic [3:0]          req_tag;
   logic                wb_valid, wb_ready;
   logic [2:0]          wb_warp;
   logic [4:0]          wb_addr;
   logic [LANES-1:0]    wb_mask;
   logic [LANES*DW-1:0] wb_data;
   logic [LANES-1:0]    rf_read_en_0, rf_read_en_1, rf_write_en;
   logic [4:0]          rf_raddr_0, rf_raddr_1, rf_waddr;
   logic [LANES*DW-1:0] rf_wdata, rf_rdata_0, rf_rdata_1;
   logic [2:0]          rf_warp_selector;
   logic                op_valid, op_ready;
   logic [2:0]          op_warp;
   logic [3:0]          op_tag;
   logic [LANES-1:0]    op_mask;
   logic [LANES*DW-1:0] op_data_0, op_data_1;

   regfile_access_ctrl #(.LANES(LANES), .DW(DW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_warp(req_warp),
      .req_rs0(req_rs0), .req_rs1(req_rs1), .req_use_rs1(req_use_rs1),
      .req_mask(req_mask), .req_tag(req_tag),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp),
      .wb_addr(wb_addr), .wb_mask(wb_mask), .wb_data(wb_data),
      .rf_read_en_0(rf_read_en_0), .rf_read_en_1(rf_read_en_1), .rf_write_en(rf_write_en),
      .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .rf_warp_selector(rf_warp_selector),
      .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1),
      .op_valid(op_valid), .op_ready(op_ready), .op_warp(op_warp), .op_tag(op_tag),
      .op_mask(op_mask), .op_data_0(op_data_0), .op_data_1(op_data_1)
   );

   typedef struct packed {
      logic [2:0]                 warp;
      logic [3:0]                 tag;
      logic [LANES-1:0]           mask;
      logic [LANES-1:0][DW-1:0]   d0;
      logic [LANES-1:0][DW-1:0]   d1;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [DW-1:0] mem  [8][32][LANES];
   logic [DW-1:0] gold [8][32][LANES];
   logic          mem_ok = 1'b0;
   int            n_tests = 0;
   int            n_fail  = 0;

   function automatic logic [DW-1:0] init_val(int w, int r, int l);
      return 64'hC000_0000_0000_0000 | (64'(w) << 40) | (64'(r) << 20) | (64'(l) + 64'd1);
   endfunction

   // register file model: combinational read, write at the edge
   always @(posedge clk) begin
      if (!mem_ok) begin
         for (int w = 0; w < 8; w++)
            for (int r = 0; r < 32; r++)
               for (int l = 0; l < LANES; l++) mem[w][r][l] <= init_val(w, r, l);
         mem_ok <= 1'b1;
      end else begin
         for (int l = 0; l < LANES; l++)
            if (rf_write_en[l]) mem[rf_warp_selector][rf_waddr][l] <= rf_wdata[l*DW +: DW];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_rd
      assign rf_rdata_0[g*DW +: DW] = mem[rf_warp_selector][rf_raddr_0][g];
      assign rf_rdata_1[g*DW +: DW] = mem[rf_warp_selector][rf_raddr_1][g];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic void gold_wr(input logic [2:0] w, input logic [4:0] a,
                                   input logic [LANES-1:0] m, input logic [DW-1:0] base);
      for (int l = 0; l < LANES; l++)
         if (m[l]) gold[w][a][l] = base + DW'(l);
   endfunction

   function automatic void push_exp(input logic [2:0] w, input logic [4:0] a0, input logic [4:0] a1,
                                    input logic u, input logic [LANES-1:0] m, input logic [3:0] t);
      exp_t e;
      e.warp = w; e.tag = t; e.mask = m;
      for (int l = 0; l < LANES; l++) begin
         e.d0[l] = m[l] ? gold[w][a0][l] : '0;
         e.d1[l] = (m[l] && u) ? gold[w][a1][l] : '0;
      end
      exp_q.push_back(e);
   endfunction

   task automatic set_wb(input logic [2:0] w, input logic [4:0] a,
                         input logic [LANES-1:0] m, input logic [DW-1:0] base);
      wb_warp = w; wb_addr = a; wb_mask = m;
      for (int l = 0; l < LANES; l++) wb_data[l*DW +: DW] = base + DW'(l);
   endtask

   // all drivers start and end at posedge+1
   task automatic do_wb(input logic [2:0] w, input logic [4:0] a,
                        input logic [LANES-1:0] m, input logic [DW-1:0] base);
      int n = 0;
      set_wb(w, a, m, base);
      wb_valid = 1'b1;
      @(negedge clk);
      while (!wb_ready && n < 100) begin @(negedge clk); n++; end
      chk("wb_timeout", 64'(n < 100), 64'd1);
      gold_wr(w, a, m, base);
      @(posedge clk); #1;
      wb_valid = 1'b0;
   endtask

   task automatic send_req(input logic [2:0] w, input logic [4:0] a0, input logic [4:0] a1,
                           input logic u, input logic [LANES-1:0] m, input logic [3:0] t);
      int n = 0;
      req_valid = 1'b1; req_warp = w; req_rs0 = a0; req_rs1 = a1;
      req_use_rs1 = u; req_mask = m; req_tag = t;
      @(negedge clk);
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      chk("req_timeout", 64'(n < 100), 64'd1);
      push_exp(w, a0, a1, u, m, t);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      chk("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   // scoreboard: compare every operand packet as it is handed off
   always @(negedge clk) begin
      if (rst_n && op_valid && op_ready) begin
         if (exp_q.size() == 0) chk("unexpected_op", 64'd1, 64'd0);
         else begin
            mon_e = exp_q.pop_front();
            chk("op_warp", 64'(op_warp), 64'(mon_e.warp));
            chk("op_tag",  64'(op_tag),  64'(mon_e.tag));
            chk("op_mask", 64'(op_mask), 64'(mon_e.mask));
            for (int l = 0; l < LANES; l++) begin
               chk($sformatf("op_d0[%0d]", l), op_data_0[l*DW +: DW], mon_e.d0[l]);
               chk($sformatf("op_d1[%0d]", l), op_data_1[l*DW +: DW], mon_e.d1[l]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      req_valid = 0; req_warp = 0; req_rs0 = 0; req_rs1 = 0; req_use_rs1 = 0;
      req_mask = 0; req_tag = 0; wb_valid = 0; wb_warp = 0; wb_addr = 0;
      wb_mask = 0; wb_data = '0; op_ready = 1;
      for (int w = 0; w < 8; w++)
         for (int r = 0; r < 32; r++)
            for (int l = 0; l < LANES; l++) gold[w][r][l] = init_val(w, r, l);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_op_valid",  64'(op_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_wb_ready",  64'(wb_ready), 64'd1);
      chk("rst_sel",       64'(rf_warp_selector), 64'd0);
      chk("rst_rden0",     64'(rf_read_en_0), 64'd0);
      chk("rst_op_tag",    64'(op_tag), 64'd0);
      @(posedge clk); #1;

      // write then read back, one-cycle latency
      do_wb(3'd2, 5'd5, 16'hFFFF, 64'hA5A5_0000_0000_0001);
      send_req(3'd2, 5'd5, 5'd5, 1'b1, 16'hFFFF, 4'h1);
      @(negedge clk);
      @(negedge clk);
      chk("lat_op_valid", 64'(op_valid), 64'd1);
      drain();

      // partial mask, single operand
      send_req(3'd1, 5'd3, 5'd9, 1'b0, 16'h00F0, 4'h2);
      @(negedge clk);
      chk("pm_rden0", 64'(rf_read_en_0), 64'h00F0);
      chk("pm_rden1", 64'(rf_read_en_1), 64'h0000);
      drain();

      // same-cycle same-warp writeback bypass
      gold_wr(3'd4, 5'd7, 16'h0003, 64'hD00D_0000_0000_0000);
      send_req(3'd4, 5'd7, 5'd8, 1'b1, 16'hFFFF, 4'h3);
      set_wb(3'd4, 5'd7, 16'h0003, 64'hD00D_0000_0000_0000);
      wb_valid = 1'b1;
      @(negedge clk);
      chk("byp_wb_ready", 64'(wb_ready), 64'd1);
      chk("byp_rden0",    64'(rf_read_en_0), 64'hFFFF);
      chk("byp_wren",     64'(rf_write_en), 64'h0003);
      @(posedge clk); #1;
      wb_valid = 1'b0;
      drain();

      // starvation: continuous foreign-warp writebacks
      gold_wr(3'd0, 5'd1, 16'hFFFF, 64'h0B0B_0000_0000_0000);
      set_wb(3'd0, 5'd1, 16'hFFFF, 64'h0B0B_0000_0000_0000);
      wb_valid = 1'b1;
      send_req(3'd6, 5'd2, 5'd3, 1'b1, 16'h0F0F, 4'h4);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("stv_wb_ready_c%0d", c), 64'(wb_ready), 64'(c < 5));
         chk($sformatf("stv_rden0_c%0d", c), 64'(rf_read_en_0), (c == 5) ? 64'h0F0F : 64'd0);
      end
      @(negedge clk);
      chk("stv_wb_ready_after", 64'(wb_ready), 64'd1);
      chk("stv_cnt_clear", 64'(dut.r_starve_cnt), 64'd0);
      @(posedge clk); #1;
      wb_valid = 1'b0;
      drain();

      // output backpressure, then back-to-back drain
      op_ready = 1'b0;
      send_req(3'd3, 5'd10, 5'd11, 1'b1, 16'hFFFF, 4'h5);
      send_req(3'd5, 5'd12, 5'd13, 1'b1, 16'hAAAA, 4'h6);
      fork
         send_req(3'd6, 5'd14, 5'd15, 1'b0, 16'h5555, 4'h7);
         begin
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               chk("hold_valid", 64'(op_valid), 64'd1);
               chk("hold_tag",   64'(op_tag), 64'h5);
               chk("hold_d0",    op_data_0[DW-1:0], gold[3][10][0]);
               chk("hold_req_ready", 64'(req_ready), 64'd0);
            end
            @(posedge clk); #1;
            op_ready = 1'b1;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               chk("b2b_valid", 64'(op_valid), 64'd1);
            end
         end
      join
      @(posedge clk); #1;
      drain();

      // reset with S1 and output occupied
      op_ready = 1'b0;
      send_req(3'd7, 5'd1, 5'd2, 1'b1, 16'hFFFF, 4'h8);
      send_req(3'd7, 5'd3, 5'd4, 1'b1, 16'hFFFF, 4'h9);
      rst_n = 1'b0;
      #1;
      chk("mrst_op_valid",  64'(op_valid), 64'd0);
      chk("mrst_req_ready", 64'(req_ready), 64'd1);
      chk("mrst_wb_ready",  64'(wb_ready), 64'd1);
      chk("mrst_rden0",     64'(rf_read_en_0), 64'd0);
      chk("mrst_rden1",     64'(rf_read_en_1), 64'd0);
      chk("mrst_wren",      64'(rf_write_en), 64'd0);
      chk("mrst_sel",       64'(rf_warp_selector), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      op_ready = 1'b1;
      @(posedge clk); #1;
      send_req(3'd2, 5'd5, 5'd0, 1'b0, 16'h8001, 4'hA);
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_valid", 64'(op_valid), 64'd1);
      drain();

      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
